// File: rtl/ex_flag_if.sv
// EX flag stage bus: ALU-side inputs, stage control and registered outputs.
// Master drives ALU results and control; slave is the flag stage.
interface ex_flag_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] alu_out;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       op_q;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             halted;

  modport master (
    output in_valid, op, A, B, alu_out,
    output stall, flush,
    input  out_valid, result, op_q,
    input  flag_z, flag_v, flag_n, halted
  );

  modport slave (
    input  in_valid, op, A, B, alu_out,
    input  stall, flush,
    output out_valid, result, op_q,
    output flag_z, flag_v, flag_n, halted
  );
endinterface

// File: rtl/ex_flag_stage.sv
// EX back end: registers ALU result into EX/MEM and
// maintains Z/V/N flags, stall/flush and sticky halt.
module ex_flag_stage #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  ex_flag_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam int MSB = WIDTH - 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] raw_diff;
  logic             v_add;
  logic             v_sub;
  logic             is_add;
  logic             is_sub;
  logic             is_zonly;

  assign raw_sum  = bus.A + bus.B;
  assign raw_diff = bus.A - bus.B;
  assign v_add = (bus.A[MSB] == bus.B[MSB])
               & (raw_sum[MSB] != bus.A[MSB]);
  assign v_sub = (bus.A[MSB] != bus.B[MSB])
               & (raw_diff[MSB] != bus.A[MSB]);

  assign is_add   = (bus.op == OP_ADD);
  assign is_sub   = (bus.op == OP_SUB);
  assign is_zonly = (bus.op == OP_XOR)
                  | (bus.op == OP_SLL)
                  | (bus.op == OP_SRA)
                  | (bus.op == OP_ROR);

  // Next state: halt/flush/stall priority, then accept with flag update
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    op_d        = op_q;
    z_d         = z_q;
    v_d         = v_q;
    n_d         = n_q;
    if (state_q == HALTED) begin
      out_valid_d = 1'b0;
    end else if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (bus.stall) begin
      out_valid_d = out_valid_q;
    end else if (bus.in_valid) begin
      out_valid_d = 1'b1;
      result_d    = bus.alu_out;
      op_d        = bus.op;
      unique case (1'b1)
        is_add: begin
          z_d = (bus.alu_out == '0);
          n_d = bus.alu_out[MSB];
          v_d = v_add;
        end
        is_sub: begin
          z_d = (bus.alu_out == '0);
          n_d = bus.alu_out[MSB];
          v_d = v_sub;
        end
        is_zonly: begin
          z_d = (bus.alu_out == '0);
        end
        default: ;
      endcase
      if (bus.op == OP_HLT) state_d = HALTED;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State and EX/MEM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      op_q        <= '0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      op_q        <= op_d;
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.op_q      = op_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_n    = n_q;
  assign bus.halted    = (state_q == HALTED);
endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage.
// Hand-computed vectors cover flags, stall/flush, halt and reset.
module tb_ex_flag_stage;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ex_flag_if #(.WIDTH(16)) bus ();

  ex_flag_stage #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [3:0]  o,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] y,
    input logic        st,
    input logic        fl
  );
    bus.in_valid = v;
    bus.op       = o;
    bus.A        = a;
    bus.B        = b;
    bus.alu_out  = y;
    bus.stall    = st;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic        ov,
    input logic [15:0] res,
    input logic [2:0]  zvn,
    input logic        h
  );
    chk({tag, ".ov"}, {31'd0, bus.out_valid}, {31'd0, ov});
    chk({tag, ".res"}, {16'd0, bus.result}, {16'd0, res});
    chk({tag, ".zvn"},
        {29'd0, bus.flag_z, bus.flag_v, bus.flag_n},
        {29'd0, zvn});
    chk({tag, ".halt"}, {31'd0, bus.halted}, {31'd0, h});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 4'h0;
    bus.A        = 16'h0;
    bus.B        = 16'h0;
    bus.alu_out  = 16'h0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    #1;
    chk_out("rst", 1'b0, 16'h0000, 3'b000, 1'b0);
    chk("rst.op", {28'd0, bus.op_q}, 32'd0);
    #11 rst_n = 1'b1;

    // ADD positive overflow, saturated result
    drive(1, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 0);
    chk_out("add_ovf", 1'b1, 16'h7FFF, 3'b010, 1'b0);
    chk("add_ovf.op", {28'd0, bus.op_q}, 32'd0);

    // SUB to zero, then XOR only touches Z
    drive(1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 0, 0);
    chk_out("sub_zero", 1'b1, 16'h0000, 3'b100, 1'b0);
    drive(1, 4'h2, 16'h1234, 16'h9234, 16'h8000, 0, 0);
    chk_out("xor", 1'b1, 16'h8000, 3'b000, 1'b0);

    // ADD negative overflow -> V=1 N=1; XOR zero -> Z=1
    drive(1, 4'h0, 16'h8000, 16'hFFFF, 16'h8000, 0, 0);
    chk_out("add_neg", 1'b1, 16'h8000, 3'b011, 1'b0);
    drive(1, 4'h2, 16'h5555, 16'h5555, 16'h0000, 0, 0);
    chk_out("xor_z", 1'b1, 16'h0000, 3'b111, 1'b0);

    // PADDSB writes no flags
    drive(1, 4'h7, 16'h7777, 16'h7777, 16'h7777, 0, 0);
    chk_out("paddsb", 1'b1, 16'h7777, 3'b111, 1'b0);
    chk("paddsb.op", {28'd0, bus.op_q}, 32'd7);

    // SLL nonzero clears Z only
    drive(1, 4'h4, 16'h0001, 16'h0004, 16'h0010, 0, 0);
    chk_out("sll", 1'b1, 16'h0010, 3'b011, 1'b0);

    // ADD no overflow, then SUB held by 3-cycle stall
    drive(1, 4'h0, 16'h0001, 16'h0002, 16'h0003, 0, 0);
    chk_out("add_small", 1'b1, 16'h0003, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1, 0);
      chk_out("stall", 1'b1, 16'h0003, 3'b000, 1'b0);
      chk("stall.op", {28'd0, bus.op_q}, 32'd0);
    end
    drive(1, 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0);
    chk_out("unstall", 1'b1, 16'hFFFE, 3'b001, 1'b0);
    chk("unstall.op", {28'd0, bus.op_q}, 32'd1);

    // SUB signed overflow: 0x8000 - 1
    drive(1, 4'h1, 16'h8000, 16'h0001, 16'h8000, 0, 0);
    chk_out("sub_ovf", 1'b1, 16'h8000, 3'b011, 1'b0);

    // flush wins over stall; then idle
    drive(1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 1, 1);
    chk_out("flush_stall", 1'b0, 16'h8000, 3'b011, 1'b0);
    drive(0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    chk_out("idle", 1'b0, 16'h8000, 3'b011, 1'b0);

    // HLT pulses out_valid, then nothing is accepted
    drive(1, 4'hF, 16'h0000, 16'h0000, 16'h1234, 0, 0);
    chk_out("hlt", 1'b1, 16'h1234, 3'b011, 1'b1);
    chk("hlt.op", {28'd0, bus.op_q}, 32'd15);
    drive(1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    chk_out("halted_add", 1'b0, 16'h1234, 3'b011, 1'b1);
    drive(1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 1, 0);
    chk_out("halted_stall", 1'b0, 16'h1234, 3'b011, 1'b1);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 3'b000, 1'b0);
    chk("async_rst.op", {28'd0, bus.op_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // no residual halt after reset
    drive(1, 4'h0, 16'h0002, 16'h0003, 16'h0005, 0, 0);
    chk_out("post_rst", 1'b1, 16'h0005, 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-stage back end for the 16-bit datapath. Sits directly downstream of the ALU: it consumes the ALU operands, opcode and combinational result, then registers the result into the EX/MEM boundary and maintains the architectural Z/V/N flag register under per-opcode update rules. It also applies stall/flush control and holds a sticky halt state once HLT retires.

## Interface
- `WIDTH`, default 16: datapath width. Only 16 is supported.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: the ALU inputs this cycle carry a real instruction.
- `op`  in  4: ALU opcode. ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111, HLT=1111.
- `A`, `B`  in  16 each: ALU operands, as presented to the ALU.
- `alu_out`  in  16: ALU result. ADD and SUB results are already saturated.
- `stall`  in  1: hold all state.
- `flush`  in  1: squash the current input.
- `out_valid`  out  1: registered result is valid.
- `result`  out  16: registered `alu_out`.
- `op_q`  out  4: registered opcode.
- `flag_z`, `flag_v`, `flag_n`  out  1 each: architectural flags.
- `halted`  out  1: sticky; HLT has retired.

## Operation
- An input is accepted when `in_valid & ~stall & ~flush & ~halted`.
- On accept:
  - `result` <= `alu_out`.
  - `op_q` <= `op`.
  - `out_valid` <= 1.
  - Flags update per the rules below.
- Flag rules are applied only on accept:
  - ADD and SUB write N, Z and V.
  - XOR, SLL, SRA and ROR write Z only; N and V are retained.
  - RED, PADDSB, HLT and all other opcodes write no flags.
- Flag values:
  - Z = (`alu_out` == 0).
  - N = `alu_out[15]`, taken from the saturated result.
  - V for ADD = (A[15]==B[15]) & (raw_sum[15]!=A[15]), with raw_sum = A+B truncated to 16 bits.
  - V for SUB = (A[15]!=B[15]) & (raw_diff[15]!=A[15]), with raw_diff = A−B.
  - Raw sum and difference are computed internally, not taken from `alu_out`.
- State machine:
  - RUN -> HALTED when HLT (op=1111) is accepted. `out_valid` pulses for the HLT itself.
  - HALTED is left only by reset. While HALTED, nothing is accepted and `out_valid` is 0.
- Priority, highest first: reset > flush > stall > accept.
  - flush: `out_valid` <= 0 next edge; `result`, `op_q` and flags are unchanged. A flush also overrides a simultaneous stall.
  - stall (no flush): every register holds, including `out_valid`.
  - Input with `in_valid`=0, no stall, no flush: `out_valid` <= 0; other registers hold.

## Timing
- Latency: 1 cycle. Inputs accepted at edge k appear on `result`, `op_q` and the flags after edge k.
- The flags seen by the instruction accepted at edge k+1 are the values written at edge k. There is no same-cycle forwarding.
- Reset: asynchronous assert clears the outputs immediately and the state goes to RUN. Reset values:
  - `out_valid` = 0
  - `result` = 0x0000
  - `op_q` = 0000
  - `flag_z`, `flag_v`, `flag_n` = 0
  - `halted` = 0
- Reset release is synchronous to the design. The first accept is possible on the first rising edge with `rst_n`=1.
- Reset mid-HLT or mid-stall discards all state, with no residual halt.
- `stall` held for N cycles leaves the outputs stable for N cycles. The next non-stalled edge accepts the input present at that edge.

## Test plan
- ADD, A=0x7FFF, B=0x0001, `alu_out`=0x7FFF → after 1 edge: `result`=0x7FFF, V=1, N=0, Z=0, `out_valid`=1.
- SUB, A=0x0005, B=0x0005, `alu_out`=0x0000 → Z=1, N=0, V=0. Then XOR with `alu_out`=0x8000 → Z=0; N and V still 0.
- Prior flags Z=1, V=1, N=1, then PADDSB A=B=0x7777, `alu_out`=0x7777 → `result`=0x7777; flags stay 1/1/1.
- ADD accepted, then `stall`=1 for 3 cycles with a SUB presented → outputs frozen 3 cycles. Release → SUB result registered on the next edge. `flush`+`stall` together → `out_valid`=0, flags unchanged.
- HLT accepted → `halted`=1, `out_valid`=1 for one cycle. A following ADD `alu_out`=0x0000 → no flag change, `out_valid`=0. Assert `rst_n`=0 asynchronously → all outputs 0 before the next edge.
